// File: rtl/arilla_bus_pkg.sv
// rtl/arilla_bus_pkg.sv - shared constants, state type and width helpers for the bus arbiter
package arilla_bus_pkg;

  localparam int ByteSize = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / ByteSize;
  endfunction

  function automatic int word_address_width(input int byte_address_width, input int data_width);
    return byte_address_width - $clog2(data_width / ByteSize);
  endfunction

endpackage

// File: rtl/arilla_rr_arbiter.sv
// rtl/arilla_rr_arbiter.sv - round-robin pick of the first requester at or after the pointer
module arilla_rr_arbiter
  import arilla_bus_pkg::*;
#(
  parameter int NumManagers = 2,
  parameter int IdxW        = $clog2(NumManagers)
) (
  input  logic [NumManagers-1:0] req,
  input  logic [IdxW-1:0]        ptr,
  output logic [IdxW-1:0]        grant,
  output logic                   any_req
);

  // Scan offsets from far to near so the requester closest to ptr is assigned last and wins
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = |req;
    for (int k = NumManagers - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NumManagers;
      if (req[idx]) grant = IdxW'(idx);
    end
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// rtl/arilla_bus_arbiter.sv - N-manager to one-subordinate round-robin bus arbiter with timeout
module arilla_bus_arbiter
  import arilla_bus_pkg::*;
#(
  parameter int NumManagers      = 2,
  parameter int DataWidth        = 32,
  parameter int ByteAddressWidth = 32,
  parameter int TimeoutCycles    = 256,
  localparam int BytesPerWord     = bytes_per_word(DataWidth),
  localparam int WordAddressWidth = word_address_width(ByteAddressWidth, DataWidth)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumManagers-1:0]                m_read,
  input  logic [NumManagers-1:0]                m_write,
  input  logic [NumManagers*WordAddressWidth-1:0] m_address,
  input  logic [NumManagers*BytesPerWord-1:0]   m_byte_enable,
  input  logic [NumManagers*DataWidth-1:0]      m_wdata,
  output logic [DataWidth-1:0]                  m_rdata,
  output logic [NumManagers-1:0]                m_available,
  output logic [NumManagers-1:0]                m_error,
  output logic [NumManagers-1:0]                m_intercept,
  output logic                                  s_read,
  output logic                                  s_write,
  output logic [WordAddressWidth-1:0]           s_address,
  output logic [BytesPerWord-1:0]               s_byte_enable,
  output logic [DataWidth-1:0]                  s_wdata,
  input  logic [DataWidth-1:0]                  s_rdata,
  input  logic                                  s_available,
  input  logic                                  s_intercept
);

  localparam int IdxW = $clog2(NumManagers);
  // A disabled timeout still needs a 1-bit counter so the declarations stay legal
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  bus_state_e              state, state_next;
  logic [IdxW-1:0]         g, rr_ptr, arb_grant, ptr_after_g;
  logic [CntW-1:0]         cnt;
  logic [NumManagers-1:0]  req_vec;
  logic                    arb_any, g_req, timeout_hit;

  assign req_vec     = m_read | m_write;
  assign g_req       = req_vec[g];
  assign ptr_after_g = (g == IdxW'(NumManagers - 1)) ? '0 : g + 1'b1;
  // An aborting manager is simply released; the timeout only completes a still-pending request
  assign timeout_hit = (TimeoutCycles > 0) && (cnt == TimeoutLast) && !s_available && g_req;

  arilla_rr_arbiter #(
    .NumManagers (NumManagers),
    .IdxW        (IdxW)
  ) u_rr_arbiter (
    .req     (req_vec),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Grant latch, round-robin pointer advance and saturating BUSY-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g      <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (arb_any) begin
        g   <= arb_grant;
        cnt <= '0;
      end
    end else begin
      if (state_next == IDLE) rr_ptr <= ptr_after_g;
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  // Next state and outputs; everything is quiet in IDLE so reset silences the bus immediately
  always_comb begin
    state_next    = state;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_byte_enable = '0;
    s_wdata       = '0;
    m_rdata       = '0;
    m_available   = '0;
    m_error       = '0;
    m_intercept   = '0;
    case (state)
      IDLE: begin
        if (arb_any) state_next = BUSY;
      end
      BUSY: begin
        s_address      = m_address[int'(g) * WordAddressWidth +: WordAddressWidth];
        s_byte_enable  = m_byte_enable[int'(g) * BytesPerWord +: BytesPerWord];
        s_wdata        = m_wdata[int'(g) * DataWidth +: DataWidth];
        s_write        = m_write[g] & ~timeout_hit;
        s_read         = m_read[g] & ~m_write[g] & ~timeout_hit;
        m_rdata        = s_rdata;
        m_intercept[g] = s_intercept;
        if (s_available) begin
          m_available[g] = 1'b1;
          state_next     = IDLE;
        end else if (!g_req) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          m_available[g] = 1'b1;
          m_error[g]     = 1'b1;
          m_rdata        = '1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// tb/tb_arilla_bus_arbiter.sv - directed self-checking bench for the bus arbiter
module tb_arilla_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_read, m_write;
  logic [119:0] m_address;
  logic [15:0]  m_byte_enable;
  logic [127:0] m_wdata;
  logic [31:0]  m_rdata;
  logic [3:0]   m_available, m_error, m_intercept;
  logic         s_read, s_write;
  logic [29:0]  s_address;
  logic [3:0]   s_byte_enable;
  logic [31:0]  s_wdata, s_rdata;
  logic         s_available, s_intercept;

  logic [29:0]  addr [4];
  logic [3:0]   be   [4];
  logic [31:0]  wd   [4];

  int n_checks = 0;
  int n_errors = 0;

  assign m_address     = {addr[3], addr[2], addr[1], addr[0]};
  assign m_byte_enable = {be[3], be[2], be[1], be[0]};
  assign m_wdata       = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  arilla_bus_arbiter #(
    .NumManagers      (4),
    .DataWidth        (32),
    .ByteAddressWidth (32),
    .TimeoutCycles    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_byte_enable (m_byte_enable),
    .m_wdata       (m_wdata),
    .m_rdata       (m_rdata),
    .m_available   (m_available),
    .m_error       (m_error),
    .m_intercept   (m_intercept),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_address     (s_address),
    .s_byte_enable (s_byte_enable),
    .s_wdata       (s_wdata),
    .s_rdata       (s_rdata),
    .s_available   (s_available),
    .s_intercept   (s_intercept)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; m_read = '0; m_write = '0;
    s_rdata = '0; s_available = 1'b0; s_intercept = 1'b0;
    addr[0] = 30'h10; addr[1] = 30'h21; addr[2] = 30'h32; addr[3] = 30'h43;
    for (int k = 0; k < 4; k++) begin
      be[k] = 4'hF;
      wd[k] = 32'hA000_0000 + 32'(k);
    end

    step(); step(); #1;
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_m_available", m_available, 0);
    check("rst_m_error", m_error, 0);
    check("rst_m_rdata", m_rdata, 0);
    rst = 1'b0;

    // single read by manager 0
    m_read = 4'b0001; #1;
    check("read_idle_s_read", s_read, 0);
    step(); #1;
    check("read_s_read", s_read, 1);
    check("read_s_write", s_write, 0);
    check("read_s_address", s_address, 30'h10);
    step(); step();
    s_rdata = 32'hDEAD_BEEF; s_available = 1'b1; #1;
    check("read_m_available", m_available, 4'b0001);
    check("read_m_rdata", m_rdata, 32'hDEAD_BEEF);
    check("read_m_error", m_error, 0);
    step();
    s_available = 1'b0; m_read = '0; #1;
    check("read_bubble_avail", m_available, 0);
    check("read_bubble_s_read", s_read, 0);

    // reset in the 2nd BUSY cycle; pointer is 1 so manager 1 wins first
    m_read = 4'b0011; s_intercept = 1'b1;
    step(); #1;
    check("rstmid_grant1_addr", s_address, 30'h21);
    check("rstmid_intercept", m_intercept, 4'b0010);
    step();
    rst = 1'b1; #1;
    check("rstmid_s_read", s_read, 0);
    check("rstmid_intercept0", m_intercept, 0);
    check("rstmid_s_address", s_address, 0);
    check("rstmid_m_rdata", m_rdata, 0);
    step();
    rst = 1'b0; s_intercept = 1'b0;
    step(); #1;
    check("rstmid_regrant0", s_address, 30'h10);
    s_available = 1'b1; #1;
    check("rstmid_regrant_avail", m_available, 4'b0001);
    step();
    s_available = 1'b0; m_read = '0;

    // fairness from pointer 0 with all four requesting
    rst = 1'b1; #1; rst = 1'b0;
    m_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      check("fair_grant_addr", s_address, 64'(addr[k % 4]));
      s_available = 1'b1; #1;
      check("fair_avail", m_available, 64'(4'b0001 << (k % 4)));
      step();
      s_available = 1'b0; #1;
      check("fair_bubble_s_read", s_read, 0);
      check("fair_bubble_avail", m_available, 0);
    end
    m_read = '0;

    // read+write from manager 1 is a write
    m_read = 4'b0010; m_write = 4'b0010; be[1] = 4'b0101;
    step(); #1;
    check("rw_s_write", s_write, 1);
    check("rw_s_read", s_read, 0);
    check("rw_s_byte_enable", s_byte_enable, 4'b0101);
    check("rw_s_wdata", s_wdata, 32'hA000_0001);
    s_available = 1'b1; #1;
    check("rw_avail", m_available, 4'b0010);
    step();
    s_available = 1'b0; m_read = '0; m_write = '0; be[1] = 4'hF;

    // manager 2 aborts, manager 3 is next
    m_read = 4'b1100;
    step(); #1;
    check("abort_grant2_addr", s_address, 30'h32);
    check("abort_grant2_read", s_read, 1);
    m_read = 4'b1000; #1;
    check("abort_s_read", s_read, 0);
    check("abort_avail", m_available, 0);
    step(); #1;
    check("abort_idle_avail", m_available, 0);
    step(); #1;
    check("abort_next_addr", s_address, 30'h43);
    check("abort_next_read", s_read, 1);
    s_available = 1'b1; #1;
    check("abort_next_avail", m_available, 4'b1000);
    step();
    s_available = 1'b0; m_read = '0;

    // timeout after 8 BUSY cycles with a silent subordinate
    m_read = 4'b0001; s_rdata = 32'h1234_5678;
    step();
    for (int i = 1; i < 8; i++) begin
      #1;
      check("to_wait_avail", m_available, 0);
      check("to_wait_s_read", s_read, 1);
      step();
    end
    #1;
    check("to_avail", m_available, 4'b0001);
    check("to_error", m_error, 4'b0001);
    check("to_rdata", m_rdata, 32'hFFFF_FFFF);
    check("to_s_read", s_read, 0);
    step(); #1;
    check("to_after_avail", m_available, 0);
    check("to_after_error", m_error, 0);
    m_read = '0;

    // completion on the timeout cycle is a normal completion
    m_read = 4'b0010;
    step();
    for (int i = 1; i < 8; i++) step();
    s_available = 1'b1; s_rdata = 32'hCAFE_F00D; #1;
    check("towin_avail", m_available, 4'b0010);
    check("towin_error", m_error, 0);
    check("towin_rdata", m_rdata, 32'hCAFE_F00D);
    step();
    s_available = 1'b0; m_read = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
